clk_div_monitor: RTL and testbench
==================================

// Module: clk_div_monitor
// PURPOSE
//  Consumer stage placed directly after the even clock divider.
//  Samples the divided clock (div_clk) in the source clk domain and measures its period and high time in clk cycles.
//  Compares the measurements against the programmed ratio n.
//  Reports per-period measurements, a lock indication and a sticky error, for bring-up and in-system checking of the divider.
// PARAMETERS
//  N_W       4   width of ratio input n (matches divider ratio port)
//  CNT_W     8   width of cycle counter and measurement outputs
//  LOCK_CNT  4   consecutive good periods required before lock asserts
// PORTS
//  clk         in   1      system clock; the same clock that drives the divider
//  rst_n       in   1      asynchronous, active-low reset
//  en          in   1      monitor enable
//  div_clk     in   1      divided clock; divider output, synchronous to clk
//  n           in   N_W    expected divide ratio (even, >=2)
//  err_clr     in   1      1-cycle pulse; clears err and stuck
//  period      out  CNT_W  last measured period (clk cycles)
//  high_cnt    out  CNT_W  last measured high time (clk cycles)
//  meas_valid  out  1      1-cycle pulse; period/high_cnt updated this cycle
//  lock        out  1      LOCK_CNT consecutive good periods seen
//  err         out  1      sticky: a checked period mismatched
//  stuck       out  1      sticky: no edge seen within 2^CNT_W-1 cycles
// BEHAVIOUR
//  Reset (async): all outputs 0; state IDLE; cnt=0; good=0; div_q=0.
//  Edge detect: div_q <= div_clk each cycle; rise = div_clk & ~div_q; fall = ~div_clk & div_q.
//  FSM states:
//   - IDLE:
//     - en=1 -> SYNC.
//   - SYNC:
//     - Wait for rise, then set cnt<=1 and go -> MEAS.
//     - The first partial period is never reported.
//   - MEAS, each cycle:
//     - cnt <= cnt+1, saturating at all-ones.
//     - On fall: high_cnt <= cnt.
//     - On rise: period <= cnt, meas_valid=1 in the same registered update, cnt <= 1, run check.
//   - Any state: en=0 -> IDLE next cycle.
//     - lock<=0, good<=0.
//     - period/high_cnt hold.
//     - err/stuck hold.
//  Latency: the period register updates 1 cycle after the rising div_clk edge (edge-detect register).
//  Example: n=12 yields period=12 and high_cnt=6.
//  Check (valid_n = n>=2 and n[0]==0):
//   - Good period: period == n, zero-extended to CNT_W.
//     - good <= min(good+1, LOCK_CNT).
//     - lock = (good==LOCK_CNT), registered.
//   - Bad period: good<=0, lock<=0, err<=1.
//   - valid_n=0: measurements still reported; no check; lock=0; err unchanged.
//  Timeout:
//   - In MEAS, cnt reaching all-ones with no edge sets stuck<=1, lock<=0, good<=0 and goes -> SYNC.
//   - In SYNC, a stuck divider simply waits; stuck is not set.
//  n change:
//   - Any cycle where n != n_q (registered copy): good<=0, lock<=0, -> SYNC (when en=1).
//   - No err is raised for the period in flight.
//  Simultaneous events:
//   - err_clr together with a new mismatch: set wins (err stays 1).
//   - err_clr together with timeout: stuck stays 1.
//   - rise with timeout on the same cycle: rise wins; no stuck.
//  rst_n assert mid-period: immediate return to reset values. The next measurement starts from SYNC.
// CONFIGURATION
//  DUTY_CHECK_EN:
//   - Defined: the check also requires high_cnt == n>>1.
//     - A high-time mismatch is treated as a bad period (err<=1, good<=0).
//   - Undefined: high_cnt is measured and reported only; no duty check.
//     - Any high time with a correct period counts as good.
// STRUCTURE
//  Package clk_div_pkg:
//   - mon_state_t enum {IDLE, SYNC, MEAS}.
//   - N_W_DEF=4, CNT_W_DEF=8, LOCK_CNT_DEF=4.
//   - Function is_valid_ratio(n).
//  Sub-module edge_det:
//   - Ports: clk, rst_n, d -> rise, fall.
//   - Single flop plus gates.
//   - Reused by other divider-family blocks.
//  Top: FSM, saturating counter, measurement registers, check/lock/sticky logic.
// TESTING
//  1. Drive from the divider, n=12, en=1:
//     - meas_valid every 12 cycles, period=12, high_cnt=6.
//     - lock rises after the 4th good period.
//     - err=0.
//  2. Locked at n=12, force n=8 in the divider only (monitor n kept at 12):
//     - Next report period=8; err=1, lock=0.
//     - err_clr pulse -> err=0.
//  3. Change monitor and divider n 12->4 mid-period:
//     - lock drops the next cycle; no err.
//     - Relock after 4 periods of 4.
//  4. Hold div_clk high for 300 cycles (CNT_W=8):
//     - stuck=1 at cnt=255; lock=0.
//     - Releasing the clock resyncs and relocks.
//  5. n=7 (odd): period=7-class measurements reported; lock=0, err=0 throughout.
//  6. DUTY_CHECK_EN defined, n=8, inject high=3/low=5:
//     - err=1.
//     - Same stimulus without the macro: err=0, lock=1.
//  Also: assert rst_n mid-MEAS -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/clk_div_pkg.sv
// +----------------------------------------------------------------------+
// | clk_div_pkg : shared types, defaults and helpers for divider blocks  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    MEAS = 2'd2
  } mon_state_t;

  localparam int N_W_DEF      = 4;
  localparam int CNT_W_DEF    = 8;
  localparam int LOCK_CNT_DEF = 4;

  // Only even ratios of at least 2 can be produced by the divider.
  function automatic logic is_valid_ratio(input logic [31:0] n);
    return (n >= 32'd2) && (n[0] == 1'b0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_monitor_if.sv
// +----------------------------------------------------------------------+
// | clk_div_monitor_if : control/measurement bundle of clk_div_monitor   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface clk_div_monitor_if
  import clk_div_pkg::*;
#(
  parameter int N_W   = N_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic             en;
  logic             div_clk;
  logic [N_W-1:0]   n;
  logic             err_clr;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_cnt;
  logic             meas_valid;
  logic             lock;
  logic             err;
  logic             stuck;

  modport master (
    output en, div_clk, n, err_clr,
    input  period, high_cnt, meas_valid, lock, err, stuck
  );

  modport slave (
    input  en, div_clk, n, err_clr,
    output period, high_cnt, meas_valid, lock, err, stuck
  );

endinterface

`default_nettype wire

// File: rtl/edge_det.sv
// +----------------------------------------------------------------------+
// | edge_det : single-flop rising/falling edge detector                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

endmodule

`default_nettype wire

// File: rtl/clk_div_monitor.sv
// +----------------------------------------------------------------------+
// | clk_div_monitor : measures divided-clock period/high time, lock/err  |
// | Optional macro DUTY_CHECK_EN adds a 50% duty check.   Rev 1.0        |
// +----------------------------------------------------------------------+
`default_nettype none

module clk_div_monitor
  import clk_div_pkg::*;
#(
  parameter int N_W      = N_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int LOCK_CNT = LOCK_CNT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  clk_div_monitor_if.slave mon
);

  localparam int               GOOD_W   = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_CNT);

  mon_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [N_W-1:0]    n_q;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  high_q, high_d;
  logic              mv_q, mv_d;
  logic              lock_q, lock_d;
  logic              err_q, err_d;
  logic              stuck_q, stuck_d;

  logic              rise, fall;
  logic              n_chg;
  logic              ratio_ok;
  logic              period_good;
  logic              err_set, stuck_set;
  logic [CNT_W-1:0]  n_ext;

  edge_det u_edge_det (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (mon.div_clk),
    .rise  (rise),
    .fall  (fall)
  );

  assign n_chg    = (mon.n != n_q);
  assign n_ext    = CNT_W'(mon.n);
  assign ratio_ok = is_valid_ratio(32'(mon.n));

  // cnt_q holds the full period length on the cycle the next rise is seen.
`ifdef DUTY_CHECK_EN
  assign period_good = (cnt_q == n_ext) && (high_q == (n_ext >> 1));
`else
  assign period_good = (cnt_q == n_ext);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    good_d    = good_q;
    period_d  = period_q;
    high_d    = high_q;
    mv_d      = 1'b0;
    lock_d    = lock_q;
    err_set   = 1'b0;
    stuck_set = 1'b0;

    if (!mon.en) begin
      state_d = IDLE;
      good_d  = '0;
      lock_d  = 1'b0;
    end else if (n_chg) begin
      state_d = SYNC;
      good_d  = '0;
      lock_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = SYNC;
        SYNC: begin
          if (rise) begin
            cnt_d   = CNT_W'(1);
            state_d = MEAS;
          end
        end
        MEAS: begin
          cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
          if (fall) begin
            high_d = cnt_q;
          end
          if (rise) begin
            period_d = cnt_q;
            mv_d     = 1'b1;
            cnt_d    = CNT_W'(1);
            if (!ratio_ok) begin
              good_d = '0;
              lock_d = 1'b0;
            end else if (period_good) begin
              good_d = (good_q == GOOD_MAX) ? GOOD_MAX : good_q + 1'b1;
              lock_d = (good_d == GOOD_MAX);
            end else begin
              good_d  = '0;
              lock_d  = 1'b0;
              err_set = 1'b1;
            end
          end else if (cnt_q == CNT_MAX) begin
            // A rise on the same cycle is handled above and beats the timeout.
            stuck_set = 1'b1;
            good_d    = '0;
            lock_d    = 1'b0;
            state_d   = SYNC;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    err_d   = err_set   | (err_q   & ~mon.err_clr);
    stuck_d = stuck_set | (stuck_q & ~mon.err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      good_q   <= '0;
      n_q      <= '0;
      period_q <= '0;
      high_q   <= '0;
      mv_q     <= 1'b0;
      lock_q   <= 1'b0;
      err_q    <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      good_q   <= good_d;
      n_q      <= mon.n;
      period_q <= period_d;
      high_q   <= high_d;
      mv_q     <= mv_d;
      lock_q   <= lock_d;
      err_q    <= err_d;
      stuck_q  <= stuck_d;
    end
  end

  assign mon.period     = period_q;
  assign mon.high_cnt   = high_q;
  assign mon.meas_valid = mv_q;
  assign mon.lock       = lock_q;
  assign mon.err        = err_q;
  assign mon.stuck      = stuck_q;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_monitor.sv
// +----------------------------------------------------------------------+
// | tb_clk_div_monitor : directed + random bench with timestamp model    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_clk_div_monitor;

  localparam int N_W      = 4;
  localparam int CNT_W    = 8;
  localparam int LOCK_CNT = 4;
`ifdef DUTY_CHECK_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clk_div_monitor_if #(.N_W(N_W), .CNT_W(CNT_W)) mon_if ();

  clk_div_monitor #(.N_W(N_W), .CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (mon_if.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: period/high time from rise/fall timestamps.
  int             cyc, t_rise, m_mode, m_good;
  logic           m_prev;
  logic [N_W-1:0] m_nprev;
  int             e_period, e_high;
  logic           e_mv, e_lock, e_err, e_stuck;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; t_rise = 0; m_mode = 0; m_good = 0; m_prev = 1'b0; m_nprev = '0;
      e_period = 0; e_high = 0; e_mv = 1'b0; e_lock = 1'b0; e_err = 1'b0; e_stuck = 1'b0;
    end else begin
      bit rise, fall, eset, sset;
      int k, nv;
      cyc++;
      rise   = mon_if.div_clk && !m_prev;
      fall   = !mon_if.div_clk && m_prev;
      m_prev = mon_if.div_clk;
      eset = 1'b0; sset = 1'b0; e_mv = 1'b0;
      nv = int'(mon_if.n);
      if (!mon_if.en) begin
        m_mode = 0; m_good = 0; e_lock = 1'b0;
      end else if (mon_if.n != m_nprev) begin
        m_mode = 1; m_good = 0; e_lock = 1'b0;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (rise) begin t_rise = cyc; m_mode = 2; end
      end else begin
        k = cyc - t_rise;
        if (fall) e_high = k;
        if (rise) begin
          e_period = k; e_mv = 1'b1; t_rise = cyc;
          if (nv < 2 || (nv % 2) != 0) begin
            m_good = 0; e_lock = 1'b0;
          end else if (k == nv && (!DUTY || e_high == nv / 2)) begin
            m_good = (m_good < LOCK_CNT) ? m_good + 1 : LOCK_CNT;
            e_lock = (m_good == LOCK_CNT);
          end else begin
            m_good = 0; e_lock = 1'b0; eset = 1'b1;
          end
        end else if (k >= (1 << CNT_W) - 1) begin
          sset = 1'b1; m_good = 0; e_lock = 1'b0; m_mode = 1;
        end
      end
      m_nprev = mon_if.n;
      e_err   = eset | (e_err & !mon_if.err_clr);
      e_stuck = sset | (e_stuck & !mon_if.err_clr);
    end
  end

  always @(negedge clk) begin
    checks++;
    if (int'(mon_if.period) !== e_period || int'(mon_if.high_cnt) !== e_high ||
        mon_if.meas_valid !== e_mv || mon_if.lock !== e_lock ||
        mon_if.err !== e_err || mon_if.stuck !== e_stuck) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t period=%0d/%0d high=%0d/%0d mv=%b/%b lock=%b/%b err=%b/%b stuck=%b/%b (actual/expected)",
               $time, mon_if.period, e_period, mon_if.high_cnt, e_high, mon_if.meas_valid, e_mv,
               mon_if.lock, e_lock, mon_if.err, e_err, mon_if.stuck, e_stuck);
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic tick(input logic d);
    mon_if.div_clk = d;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int hi, input int lo, input int periods);
    for (int p = 0; p < periods; p++) begin
      repeat (hi) tick(1'b1);
      repeat (lo) tick(1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    mon_if.en = 1'b0; mon_if.div_clk = 1'b0; mon_if.n = 4'd12; mon_if.err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_period", int'(mon_if.period), 0);
    check("reset_flags", int'({mon_if.meas_valid, mon_if.lock, mon_if.err, mon_if.stuck}), 0);
    rst_n = 1'b1;
    mon_if.en = 1'b1;

    // Nominal n=12 from a 6/6 divider.
    run(6, 6, 6);
    check("t1_period", int'(mon_if.period), 12);
    check("t1_high", int'(mon_if.high_cnt), 6);
    check("t1_lock", int'(mon_if.lock), 1);
    check("t1_err", int'(mon_if.err), 0);

    // Divider jumps to 8 while monitor expects 12.
    repeat (4) tick(1'b1); repeat (4) tick(1'b0); tick(1'b1);
    check("t2_period", int'(mon_if.period), 8);
    check("t2_err", int'(mon_if.err), 1);
    check("t2_lock", int'(mon_if.lock), 0);
    repeat (5) tick(1'b1); repeat (6) tick(1'b0);
    mon_if.err_clr = 1'b1; tick(1'b1); mon_if.err_clr = 1'b0;
    check("t2_err_clr", int'(mon_if.err), 0);
    repeat (5) tick(1'b1); repeat (6) tick(1'b0);
    run(6, 6, 4);
    check("t2_relock", int'(mon_if.lock), 1);

    // Ratio change mid-period.
    repeat (3) tick(1'b1);
    mon_if.n = 4'd4;
    tick(1'b1);
    check("t3_lock_drop", int'(mon_if.lock), 0);
    run(2, 2, 7);
    check("t3_relock", int'(mon_if.lock), 1);
    check("t3_err", int'(mon_if.err), 0);
    check("t3_period", int'(mon_if.period), 4);

    // Stuck divider.
    repeat (300) tick(1'b1);
    check("t4_stuck", int'(mon_if.stuck), 1);
    check("t4_lock", int'(mon_if.lock), 0);
    repeat (2) tick(1'b0);
    run(2, 2, 7);
    check("t4_relock", int'(mon_if.lock), 1);
    check("t4_stuck_sticky", int'(mon_if.stuck), 1);
    mon_if.err_clr = 1'b1; tick(1'b1); mon_if.err_clr = 1'b0;
    check("t4_stuck_clr", int'(mon_if.stuck), 0);
    tick(1'b1); repeat (2) tick(1'b0);

    // Odd ratio: reported, never checked.
    mon_if.n = 4'd7;
    run(4, 3, 6);
    check("t5_period", int'(mon_if.period), 7);
    check("t5_high", int'(mon_if.high_cnt), 4);
    check("t5_lock", int'(mon_if.lock), 0);
    check("t5_err", int'(mon_if.err), 0);

    // Skewed duty at n=8.
    mon_if.n = 4'd8;
    run(3, 5, 7);
    check("t6_period", int'(mon_if.period), 8);
    check("t6_high", int'(mon_if.high_cnt), 3);
    check("t6_err", int'(mon_if.err), DUTY ? 1 : 0);
    check("t6_lock", int'(mon_if.lock), DUTY ? 0 : 1);
    mon_if.err_clr = 1'b1; tick(1'b1); mon_if.err_clr = 1'b0;
    repeat (2) tick(1'b1); repeat (5) tick(1'b0);

    // Random ratios, duty, enables and clears.
    for (int it = 0; it < 150; it++) begin
      int r, ratio, hi;
      r = int'($urandom_range(0, 9));
      if (r == 0) mon_if.n = N_W'($urandom_range(0, 15));
      else if (r < 3) mon_if.n = N_W'(2 * $urandom_range(1, 7));
      mon_if.en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 39) == 0) repeat (260) tick(1'b1);
      ratio = ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, 16)) : int'(mon_if.n);
      if (ratio < 2) ratio = 2;
      hi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, ratio - 1)) : ratio / 2;
      mon_if.err_clr = ($urandom_range(0, 7) == 0);
      tick(1'b1);
      mon_if.err_clr = 1'b0;
      repeat (hi - 1) tick(1'b1);
      repeat (ratio - hi) tick(1'b0);
    end

    // Asynchronous reset in the middle of a measurement.
    mon_if.en = 1'b1; mon_if.n = 4'd8; mon_if.err_clr = 1'b0;
    run(4, 4, 7);
    check("t7_pre_lock", int'(mon_if.lock), 1);
    repeat (2) tick(1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_period", int'(mon_if.period), 0);
    check("t7_rst_high", int'(mon_if.high_cnt), 0);
    check("t7_rst_flags", int'({mon_if.meas_valid, mon_if.lock, mon_if.err, mon_if.stuck}), 0);
    repeat (2) tick(1'b0);
    rst_n = 1'b1;
    run(4, 4, 7);
    check("t7_relock", int'(mon_if.lock), 1);
    check("t7_period", int'(mon_if.period), 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
